// File: rtl/watch_set_controller.sv
// Time-setting controller for an MM:SS watch: debounces mode/inc buttons, sequences
// RUN -> SET_MIN -> SET_SEC -> RUN, and drives run enable, time load, digits and blanking.
module watch_set_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 1250000,
   parameter int unsigned BLINK_CYCLES    = 62500000,
   parameter int unsigned TIMEOUT_CYCLES  = 1250000000
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] min1_in,
   input  logic [3:0] min0_in,
   input  logic [3:0] sec1_in,
   input  logic [3:0] sec0_in,
   output logic       run_en,
   output logic       load,
   output logic [3:0] min1_out,
   output logic [3:0] min0_out,
   output logic [3:0] sec1_out,
   output logic [3:0] sec0_out,
   output logic [3:0] blank,
   output logic [1:0] mode_state
);

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned BlW = $clog2(BLINK_CYCLES + 1);
   localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BlW-1:0] BlMax = BlW'(BLINK_CYCLES - 1);
   localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StRun = 2'b00, StSetMin = 2'b01, StSetSec = 2'b10} state_e;

   // Two-digit BCD increment with 59 -> 00 wrap.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
   endfunction

   function automatic logic [3:0] clean(input logic [3:0] d, input logic [3:0] max_d);
      return (d > max_d) ? 4'd0 : d;
   endfunction

   logic [1:0]     raw, sync1, sync2, deb, press;
   logic [DbW-1:0] db_cnt [2];

   assign raw = {btn_inc, btn_mode};

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 2'b00;
         sync2     <= 2'b00;
         deb       <= 2'b00;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int b = 0; b < 2; b++) begin
            if (sync2[b] == deb[b]) begin
               db_cnt[b] <= '0;
            end else if (db_cnt[b] == DbMax) begin
               deb[b]    <= sync2[b];
               db_cnt[b] <= '0;
            end else begin
               db_cnt[b] <= db_cnt[b] + DbW'(1);
            end
         end
      end
   end

   // Press pulse fires in the cycle the debounced level rises.
   assign press[0] = sync2[0] & ~deb[0] & (db_cnt[0] == DbMax);
   assign press[1] = sync2[1] & ~deb[1] & (db_cnt[1] == DbMax);

   state_e         state;
   logic [15:0]    edit_q, run_q, live, live_clean, shown;
   logic [BlW-1:0] blink_cnt;
   logic [ToW-1:0] to_cnt;
   logic           phase;

   assign live       = {min1_in, min0_in, sec1_in, sec0_in};
   assign live_clean = {clean(min1_in, 4'd5), clean(min0_in, 4'd9),
                        clean(sec1_in, 4'd5), clean(sec0_in, 4'd9)};

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StRun;
         run_en    <= 1'b1;
         load      <= 1'b0;
         edit_q    <= '0;
         run_q     <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         to_cnt    <= '0;
      end else begin
         load  <= 1'b0;
         run_q <= live;
         // Free-running blink/timeout in set modes; branches below override with clears.
         if (state != StRun) begin
            if (blink_cnt == BlMax) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + BlW'(1);
            end
            to_cnt <= to_cnt + ToW'(1);
         end
         unique case (state)
            StRun: begin
               if (press[0]) begin
                  state     <= StSetMin;
                  run_en    <= 1'b0;
                  edit_q    <= live_clean;
                  blink_cnt <= '0;
                  phase     <= 1'b0;
                  to_cnt    <= '0;
               end
            end
            StSetMin: begin
               if (press[0]) begin
                  state     <= StSetSec;
                  blink_cnt <= '0;
                  phase     <= 1'b0;
                  to_cnt    <= '0;
               end else if (press[1]) begin
                  edit_q[15:8] <= bcd_inc(edit_q[15:8]);
                  blink_cnt    <= '0;
                  phase        <= 1'b0;
                  to_cnt       <= '0;
               end else if (to_cnt == ToMax) begin
                  state  <= StRun;
                  run_en <= 1'b1;
               end
            end
            StSetSec: begin
               if (press[0]) begin
                  state  <= StRun;
                  run_en <= 1'b1;
                  load   <= 1'b1;
               end else if (press[1]) begin
                  edit_q[7:0] <= bcd_inc(edit_q[7:0]);
                  blink_cnt   <= '0;
                  phase       <= 1'b0;
                  to_cnt      <= '0;
               end else if (to_cnt == ToMax) begin
                  state  <= StRun;
                  run_en <= 1'b1;
               end
            end
            default: begin
               state  <= StRun;
               run_en <= 1'b1;
            end
         endcase
      end
   end

   // The load cycle shows the edited value even though the state is already RUN.
   assign shown = (state == StRun && !load) ? run_q : edit_q;
   assign {min1_out, min0_out, sec1_out, sec0_out} = shown;
   assign blank = (state == StSetMin) ? {phase, phase, 2'b00} :
                  (state == StSetSec) ? {2'b00, phase, phase} : 4'b0000;
   assign mode_state = state;

endmodule

// File: tb/tb_watch_set_controller.sv
// Scoreboard bench for watch_set_controller: a high-level watch model queues expected
// mode/digit events per button press; a negedge monitor pops and checks them.
module tb_watch_set_controller;

   localparam int unsigned DEB   = 4;
   localparam int unsigned BLINK = 8;
   localparam int unsigned TMO   = 64;

   logic       sysclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [3:0] min1_in = 4'd0, min0_in = 4'd0, sec1_in = 4'd0, sec0_in = 4'd0;
   logic [3:0] min1_out, min0_out, sec1_out, sec0_out, blank;
   logic       run_en, load;
   logic [1:0] mode_state;

   always #5 sysclk = ~sysclk;

   watch_set_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .BLINK_CYCLES   (BLINK),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .min1_in   (min1_in),
      .min0_in   (min0_in),
      .sec1_in   (sec1_in),
      .sec0_in   (sec0_in),
      .run_en    (run_en),
      .load      (load),
      .min1_out  (min1_out),
      .min0_out  (min0_out),
      .sec1_out  (sec1_out),
      .sec0_out  (sec0_out),
      .blank     (blank),
      .mode_state(mode_state)
   );

   typedef struct packed {
      logic [1:0]  st;
      logic        ld;
      logic [15:0] d;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail = 0;
   bit  done = 1'b0;

   // Reference model: mode 0 run, 1 set minutes, 2 set seconds; time as plain integers.
   int m_mode = 0;
   int m_min = 0;
   int m_sec = 0;

   function automatic logic [15:0] bcd_of(input int mm, input int ss);
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic int digit_ok(input int d, input int lim);
      return (d > lim) ? 0 : d;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic expect_ev(input int st, input bit ld);
      ev_t e;
      e.st = 2'(st);
      e.ld = ld;
      e.d  = bcd_of(m_min, m_sec);
      exp_q.push_back(e);
   endtask

   task automatic set_in(input logic [15:0] v);
      {min1_in, min0_in, sec1_in, sec0_in} = v;
   endtask

   task automatic press(input bit m, input bit i);
      if (m) begin
         case (m_mode)
            0: begin
               m_min  = digit_ok(int'(min1_in), 5) * 10 + digit_ok(int'(min0_in), 9);
               m_sec  = digit_ok(int'(sec1_in), 5) * 10 + digit_ok(int'(sec0_in), 9);
               m_mode = 1;
               expect_ev(1, 1'b0);
            end
            1: begin
               m_mode = 2;
               expect_ev(2, 1'b0);
            end
            default: begin
               m_mode = 0;
               expect_ev(0, 1'b1);
            end
         endcase
      end else if (i && m_mode != 0) begin
         if (m_mode == 1) m_min = (m_min + 1) % 60;
         else m_sec = (m_sec + 1) % 60;
         expect_ev(m_mode, 1'b0);
      end
      btn_mode = m;
      btn_inc  = i;
      cyc($urandom_range(8, 14));
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cyc($urandom_range(8, 14));
   endtask

   task automatic glitch(input bit which);
      if (which) btn_inc = 1'b1;
      else btn_mode = 1'b1;
      cyc(3);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cyc(10);
   endtask

   task automatic timeout_idle();
      if (m_mode != 0) begin
         m_mode = 0;
         expect_ev(0, 1'b0);
      end
      cyc(TMO + 16);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      cyc(3);
      rst_n  = 1'b1;
      m_mode = 0;
      m_min  = 0;
      m_sec  = 0;
   endtask

   initial begin
      logic [15:0] v;
      int a;
      set_in(16'h1234);
      rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(200);
      glitch(1'b0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      set_in(16'h5807);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      set_in(16'h1257);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      repeat (3) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      timeout_idle();
      press(1'b1, 1'b0);
      cyc(5);
      reset_pulse();
      cyc(5);
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      press(1'b1, 1'b0);
      for (int s = 0; s < 80; s++) begin
         a = $urandom_range(0, 9);
         if (m_mode == 0) begin
            if (a < 2) begin
               if ($urandom_range(0, 3) == 0) v = 16'($urandom);
               else v = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
               set_in(v);
               cyc(2);
            end else if (a < 3) begin
               glitch(1'($urandom_range(0, 1)));
            end else if (a < 7) begin
               press(1'b1, a == 6);
            end else begin
               press(1'b0, 1'b1);
            end
         end else begin
            if (a == 0) timeout_idle();
            else if (a < 4) press(1'b1, a == 3);
            else press(1'b0, 1'b1);
         end
      end
      cyc(20);
      done = 1'b1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   logic [1:0]  prev_s;
   logic [15:0] prev_d, prev_in;
   bit          prev_ok = 1'b0;
   int          k = 0;

   always @(negedge sysclk) begin
      logic [15:0] cur_d, cur_in;
      logic [3:0]  exp_blank;
      bit          p, ev;
      ev_t         e;
      cur_d  = {min1_out, min0_out, sec1_out, sec0_out};
      cur_in = {min1_in, min0_in, sec1_in, sec0_in};
      if (!rst_n) begin
         check(mode_state == 2'd0 && !load && run_en && blank == 4'd0, "reset_outputs",
               32'({mode_state, load, run_en, blank}), 32'h10);
         prev_ok = 1'b0;
      end else begin
         check(run_en == (mode_state == 2'd0), "run_en", 32'(run_en), 32'(mode_state == 2'd0));
         if (prev_ok) begin
            ev = load || mode_state != prev_s || (mode_state != 2'd0 && cur_d != prev_d);
            if (ev) begin
               check(exp_q.size() != 0, "unexpected_event", 32'({mode_state, load, cur_d}), 0);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check(e.st == mode_state && e.ld == load, "event_state",
                        32'({mode_state, load}), 32'({e.st, e.ld}));
                  if (mode_state != 2'd0 || load)
                     check(cur_d == e.d, "event_digits", 32'(cur_d), 32'(e.d));
               end
            end
            if (prev_s != 2'd0 && mode_state == 2'd0 && !load)
               check(k == int'(TMO) - 1, "timeout_len", 32'(k), 32'(TMO - 1));
            if (mode_state == 2'd0 && !load)
               check(cur_d == prev_in, "run_digits", 32'(cur_d), 32'(prev_in));
            if (mode_state != 2'd0)
               k = (mode_state != prev_s || cur_d != prev_d) ? 0 : k + 1;
         end else begin
            k = 0;
         end
         p = ((k / int'(BLINK)) % 2) == 1;
         case (mode_state)
            2'd1:    exp_blank = {p, p, 2'b00};
            2'd2:    exp_blank = {2'b00, p, p};
            default: exp_blank = 4'b0000;
         endcase
         check(blank == exp_blank, "blank", 32'(blank), 32'(exp_blank));
         prev_s  = mode_state;
         prev_d  = cur_d;
         prev_in = cur_in;
         prev_ok = 1'b1;
      end
      if (done) begin
         check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 0);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
   end

endmodule
